// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared types and constants for the exception sequencer
package exc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE_EPC,
    ST_MEM_REQ,
    ST_MEM_WAIT,
    ST_LOAD_PC,
    ST_DONE
  } exc_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_OPCODE = 2'b01,
    CAUSE_OVF    = 2'b10,
    CAUSE_DIV0   = 2'b11
  } exc_cause_t;

  localparam logic [2:0] SEL_PC  = 3'b000;
  localparam logic [2:0] SEL_VEC = 3'b110;

  localparam logic [7:0] VEC_OPCODE_DEF = 8'd253;
  localparam logic [7:0] VEC_OVF_DEF    = 8'd254;
  localparam logic [7:0] VEC_DIV0_DEF   = 8'd255;

endpackage

// File: rtl/exc_wait_cnt.sv
// rtl/exc_wait_cnt.sv - 4-bit loadable down-counter timing the memory wait
module exc_wait_cnt (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_en,
  output logic       o_zero
);

  logic [3:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= 4'd0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != 4'd0)) begin
      r_count <= r_count - 4'd1;
    end
  end

  assign o_zero = (r_count == 4'd0);

endmodule

// File: rtl/exc_seq_ctrl.sv
// rtl/exc_seq_ctrl.sv - exception sequencer: save EPC, fetch handler byte, load PC
module exc_seq_ctrl
  import exc_pkg::*;
#(
  parameter int unsigned MEM_LATENCY = 2,
  parameter logic [7:0]  VEC_OPCODE  = VEC_OPCODE_DEF,
  parameter logic [7:0]  VEC_OVF     = VEC_OVF_DEF,
  parameter logic [7:0]  VEC_DIV0    = VEC_DIV0_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_cur,
  input  logic [7:0]  mem_byte,
  output logic        busy,
  output logic        stall,
  output logic [2:0]  addr_sel,
  output logic [31:0] vector_addr,
  output logic        mem_rd,
  output logic        epc_wr,
  output logic [31:0] epc_data,
  output logic        pc_wr,
  output logic [31:0] pc_data,
  output logic [1:0]  exc_cause,
  output logic        done
);

  localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

  exc_state_t  r_state, w_next;
  exc_cause_t  r_cause, w_cause;
  logic [31:0] r_pc;
  logic [7:0]  r_vec, w_vec;
  logic        w_req;
  logic        w_cnt_zero;

  assign w_req = exc_opcode | exc_overflow | exc_div0;

  // Fixed priority: opcode beats overflow beats divide-by-zero.
  always_comb begin
    w_cause = CAUSE_DIV0;
    w_vec   = VEC_DIV0;
    if (exc_opcode) begin
      w_cause = CAUSE_OPCODE;
      w_vec   = VEC_OPCODE;
    end else if (exc_overflow) begin
      w_cause = CAUSE_OVF;
      w_vec   = VEC_OVF;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cause <= CAUSE_NONE;
      r_pc    <= 32'd0;
      r_vec   <= 8'd0;
    end else begin
      r_state <= w_next;
      if ((r_state == ST_IDLE) && w_req) begin
        r_cause <= w_cause;
        r_pc    <= pc_cur;
        r_vec   <= w_vec;
      end
    end
  end

  exc_wait_cnt u_wait_cnt (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_load     (r_state == ST_MEM_REQ),
    .i_load_val (LAT_M1),
    .i_en       (r_state == ST_MEM_WAIT),
    .o_zero     (w_cnt_zero)
  );

  always_comb begin
    w_next      = r_state;
    busy        = 1'b1;
    addr_sel    = SEL_PC;
    vector_addr = 32'd0;
    mem_rd      = 1'b0;
    epc_wr      = 1'b0;
    epc_data    = 32'd0;
    pc_wr       = 1'b0;
    pc_data     = 32'd0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_req) w_next = ST_SAVE_EPC;
      end
      ST_SAVE_EPC: begin
        epc_wr   = 1'b1;
        epc_data = r_pc - 32'd4;
        w_next   = ST_MEM_REQ;
      end
      ST_MEM_REQ: begin
        mem_rd      = 1'b1;
        addr_sel    = SEL_VEC;
        vector_addr = {24'd0, r_vec};
        w_next      = ST_MEM_WAIT;
      end
      ST_MEM_WAIT: begin
        addr_sel    = SEL_VEC;
        vector_addr = {24'd0, r_vec};
        if (w_cnt_zero) w_next = ST_LOAD_PC;
      end
      ST_LOAD_PC: begin
        addr_sel    = SEL_VEC;
        vector_addr = {24'd0, r_vec};
        pc_wr       = 1'b1;
        pc_data     = {24'd0, mem_byte};
        w_next      = ST_DONE;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        busy   = 1'b0;
        w_next = ST_IDLE;
      end
    endcase
  end

  assign stall     = busy;
  assign exc_cause = r_cause;

endmodule
